// File: rtl/pc_sequencer_pkg.sv
// Shared types and constants for the fetch-stage next-PC controller.
// Vectors, PC step, interrupt FSM states and redirect actions.
package pc_sequencer_pkg;

  localparam logic [31:0] RESET_VEC = 32'h0000_0000;
  localparam logic [31:0] IRQ_VEC   = 32'h8000_0004;
  localparam logic [31:0] EXC_VEC   = 32'h8000_0008;
  localparam logic [31:0] PC_STEP   = 32'd4;

  typedef enum logic {
    RUN  = 1'b0,
    PEND = 1'b1
  } irq_state_e;

  typedef enum logic [2:0] {
    BRANCH,
    EXC,
    ERET,
    JUMP,
    STALL,
    IRQ,
    SEQ
  } action_e;

endpackage

// File: rtl/pc_irq_pending.sv
// Interrupt edge detector and pending-request FSM.
// A level held high counts as one request; a take clears it.
module pc_irq_pending
  import pc_sequencer_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic irq,
  input  logic take,
  output logic pend_or_edge
);

  irq_state_e state_q, state_d;
  logic       irq_q;
  logic       rise;

  assign rise         = irq & ~irq_q;
  assign pend_or_edge = (state_q == PEND) | rise;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RUN;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      irq_q   <= irq;
    end
  end

  // An edge coinciding with the take is absorbed by it.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:  if (rise && !take) state_d = PEND;
      PEND: if (take) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// Next-PC selection, IF/ID flush strobes and the exception PC register.
// Redirects are resolved combinationally; only epc and irq state are stored.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VEC,
  parameter logic [31:0] IRQ_VECTOR   = IRQ_VEC,
  parameter logic [31:0] EXC_VECTOR   = EXC_VEC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] PC,
  input  logic        stall_req,
  input  logic        jump_req,
  input  logic [31:0] jump_target,
  input  logic        branch_req,
  input  logic [31:0] branch_target,
  input  logic        exc_req,
  input  logic        eret,
  input  logic        irq,
  output logic [31:0] PC_new,
  output logic        KeepPC,
  output logic        flush_IF,
  output logic        flush_ID,
  output logic [31:0] epc
);

  logic [31:0] epc_q, epc_d;
  logic        pend_or_edge;
  logic        hi_act;
  logic        take;
  action_e     act;

  assign hi_act = branch_req | exc_req | eret
                | jump_req | stall_req;
  assign take   = pend_or_edge & ~PC[31] & ~hi_act;

  pc_irq_pending u_pend (
    .clk          (clk),
    .reset        (reset),
    .irq          (irq),
    .take         (take),
    .pend_or_edge (pend_or_edge)
  );

  // Mask lower-priority requests so exactly one select is hot.
  logic s_br, s_exc, s_eret, s_jmp, s_stl, s_seq;

  assign s_br   = branch_req;
  assign s_exc  = exc_req & ~branch_req;
  assign s_eret = eret & ~branch_req & ~exc_req;
  assign s_jmp  = jump_req & ~(branch_req | exc_req | eret);
  assign s_stl  = stall_req
                & ~(branch_req | exc_req | eret | jump_req);
  assign s_seq  = ~hi_act & ~take;

  always_comb begin
    act = SEQ;
    unique case (1'b1)
      s_br:   act = BRANCH;
      s_exc:  act = EXC;
      s_eret: act = ERET;
      s_jmp:  act = JUMP;
      s_stl:  act = STALL;
      take:   act = IRQ;
      s_seq:  act = SEQ;
      default: act = SEQ;
    endcase
  end

  always_comb begin
    PC_new   = PC + PC_STEP;
    KeepPC   = 1'b0;
    flush_IF = 1'b0;
    flush_ID = 1'b0;
    epc_d    = epc_q;
    if (!reset) begin
      PC_new   = RESET_VECTOR;
      flush_IF = 1'b1;
      flush_ID = 1'b1;
    end else begin
      unique case (act)
        BRANCH: begin
          PC_new   = branch_target;
          flush_IF = 1'b1;
          flush_ID = 1'b1;
        end
        EXC: begin
          PC_new   = EXC_VECTOR;
          epc_d    = PC - PC_STEP;
          flush_IF = 1'b1;
          flush_ID = 1'b1;
        end
        ERET: begin
          PC_new   = epc_q;
          flush_IF = 1'b1;
        end
        JUMP: begin
          PC_new   = jump_target;
          flush_IF = 1'b1;
        end
        STALL: begin
          PC_new = PC;
          KeepPC = 1'b1;
        end
        IRQ: begin
          PC_new   = IRQ_VECTOR;
          epc_d    = PC;
          flush_IF = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) epc_q <= 32'h0;
    else        epc_q <= epc_d;
  end

  assign epc = epc_q;

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Next-PC controller for the fetch stage. Every cycle it chooses the value loaded into the PC register and whether the PC holds. It picks from sequential fetch, ID-stage jumps, EX-stage taken branches, exception entry, interrupt entry and exception return. It also drives the IF/ID flush strobes and owns the exception PC (`epc`) register. It sits between the hazard/branch logic and the PC register, driving that register's `PC_new` and `KeepPC` inputs.

## Interface
- `RESET_VECTOR`, default 32'h0000_0000: `PC_new` value while reset is asserted.
- `IRQ_VECTOR`, default 32'h8000_0004: interrupt handler entry.
- `EXC_VECTOR`, default 32'h8000_0008: undefined-instruction handler entry.
- `clk  in  1`: single clock, rising edge.
- `reset  in  1`: asynchronous, active-low.
- `PC  in  32`: current PC register value (the IF instruction address).
- `stall_req  in  1`: load-use hazard; hold PC.
- `jump_req  in  1`, `jump_target  in  32`: J/JAL/JR resolved in ID.
- `branch_req  in  1`, `branch_target  in  32`: taken branch resolved in EX.
- `exc_req  in  1`: undefined instruction in ID.
- `eret  in  1`: exception return decoded in ID.
- `irq  in  1`: external interrupt, level; only rising edges are recorded.
- `PC_new  out  32`: next PC value.
- `KeepPC  out  1`: PC register holds.
- `flush_IF  out  1`: squash the IF/ID register.
- `flush_ID  out  1`: squash the ID/EX register.
- `epc  out  32`: exception return address, registered.

## Operation
- Kernel mode is PC[31]=1. Interrupts are never taken in kernel mode.
- `PC_new`, `KeepPC` and the flushes are combinational from inputs and state. The default is `PC_new`=PC+4 with 32-bit wrap: 0xFFFF_FFFC wraps to 0x0000_0000.
- Priority, highest first; exactly one action per cycle:
  1. `branch_req`: `PC_new`=`branch_target`; `flush_IF`=1 and `flush_ID`=1.
  2. `exc_req`: `PC_new`=`EXC_VECTOR`; `epc`<=PC-4 (the ID instruction address); `flush_IF`=1 and `flush_ID`=1.
  3. `eret`: `PC_new`=`epc`; `flush_IF`=1.
  4. `jump_req`: `PC_new`=`jump_target`; `flush_IF`=1.
  5. `stall_req`: `KeepPC`=1; no flush. `PC_new`=PC.
  6. Interrupt take: `PC_new`=`IRQ_VECTOR`; `epc`<=PC; `flush_IF`=1.
  7. Otherwise: sequential fetch.
- Interrupt take condition:
  - The pending flag is set, or an `irq` rising edge occurs this cycle.
  - PC[31]=0.
  - None of actions 1-5 is active.
- Pending flag:
  - Set on an `irq` rising edge (`irq`=1 with `irq_q`=0).
  - Cleared on the cycle the interrupt is taken.
  - A rising edge in the same cycle as the take is absorbed by that take.
- FSM:
  - States RUN and PEND; state == pending flag.
  - RUN->PEND on a rising edge not taken that cycle.
  - PEND->RUN on take.
  - PEND stays PEND through redirects, stalls and kernel mode.
- `epc` changes only on an exception or interrupt take. Simultaneous `exc_req` and interrupt: the exception wins; the interrupt stays pending.

## Timing
- Reset asserted, asynchronously:
  - state=RUN, `irq_q`=0, `epc`=0.
  - Outputs forced to `PC_new`=`RESET_VECTOR`, `KeepPC`=0, `flush_IF`=1, `flush_ID`=1.
  - Reset mid-PEND discards the pending interrupt.
- Latency:
  - Zero cycles from request to `PC_new`/flush. The PC register loads `PC_new` at the same rising edge.
  - `epc`, state and `irq_q` update at that edge.
- An interrupt that loses to a redirect is taken on the first later cycle that has no higher-priority action and PC[31]=0. `epc` then records the redirected PC.
- `irq` held high for many cycles counts as one request.

## Structure
- Shared package holds:
  - Vector constants and PC_STEP=4.
  - The 1-bit state enum (RUN/PEND).
  - An action enum: BRANCH, EXC, ERET, JUMP, STALL, IRQ, SEQ.
- One sub-module: `pc_irq_pending`. It holds the edge detector plus the pending flag/FSM, with inputs `irq`, `take` and outputs `pend_or_edge`.
- The top level contains the priority encoder, the `PC_new` mux and the `epc` register.

## Test plan
- Reset held low, then released with PC=0x10 and no requests:
  - During reset: `PC_new`=0, `flush_IF`=1, `flush_ID`=1.
  - After release: `PC_new`=0x14, `KeepPC`=0, no flush.
- `branch_req` (target 0x100) + `jump_req` (0x200) + `stall_req` in the same cycle -> `PC_new`=0x100, `KeepPC`=0, `flush_IF`=1 and `flush_ID`=1.
- `stall_req` alone with PC=0x40 -> `KeepPC`=1, `PC_new`=0x40, no flush.
- `irq` rises while `jump_req` is active, PC=0x40, target 0x200:
  - Cycle 1: `PC_new`=0x200.
  - Cycle 2, PC=0x200, no requests: `PC_new`=0x8000_0004, `flush_IF`=1.
  - Next cycle: `epc`=0x200.
- `exc_req` with PC=0x84 -> `PC_new`=0x8000_0008, `flush_IF`=1 and `flush_ID`=1, then `epc`=0x80. A later `eret` -> `PC_new`=0x80.
- `irq` pulse while PC=0x8000_0100 -> no take while PC[31]=1; PC then 0x30 -> `PC_new`=0x8000_0004, `epc`=0x30. Repeat with reset pulsed low in between -> no take.
